// File: rtl/cpu_mult_arbiter.sv
// cpu_mult_arbiter
// Shares one pipelined multiplier cell between the CPU pipeline (requester 0)
// and a custom-instruction accelerator (requester 1). One issue per cycle at
// most, round-robin on contention, with a tag pipeline that follows each
// operation through the cell so the product can be steered back to its owner.

module cpu_mult_arbiter #(
   parameter int MUL_LATENCY = 1,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [DATA_W-1:0] r0_src1,
   input  logic [DATA_W-1:0] r0_src2,
   output logic              r0_resp_valid,
   input  logic              r0_resp_ready,
   output logic [DATA_W-1:0] r0_result,

   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [DATA_W-1:0] r1_src1,
   input  logic [DATA_W-1:0] r1_src2,
   output logic              r1_resp_valid,
   input  logic              r1_resp_ready,
   output logic [DATA_W-1:0] r1_result,

   output logic [DATA_W-1:0] mul_src1,
   output logic [DATA_W-1:0] mul_src2,
   input  logic [DATA_W-1:0] mul_result,

   output logic              busy
);

   localparam int LastStage = MUL_LATENCY - 1;

   // Per-requester state: outstanding flag and held response.
   logic [1:0]             r_busy;
   logic [1:0]             r_respValid;
   logic [DATA_W-1:0]      r_result0;
   logic [DATA_W-1:0]      r_result1;

   // Id of the most recent grant; the other requester wins the next tie.
   logic                   r_lastGrant;

   // Tag pipeline, one {valid, id} pair per cell stage.
   logic [MUL_LATENCY-1:0] r_tagValid;
   logic [MUL_LATENCY-1:0] r_tagId;

   logic                   w_elig0;
   logic                   w_elig1;
   logic                   w_grant0;
   logic                   w_grant1;
   logic                   w_grantAny;
   logic                   w_grantId;
   logic                   w_done0;
   logic                   w_done1;
   logic                   w_capture0;
   logic                   w_capture1;

   // Eligibility and round-robin grant; no grants while reset is held so the
   // requesters never see a handshake that the reset is about to discard.
   always_comb begin
      w_elig0    = r0_valid & ~r_busy[0] & ~reset;
      w_elig1    = r1_valid & ~r_busy[1] & ~reset;
      w_grant0   = w_elig0 & (~w_elig1 | r_lastGrant);
      w_grant1   = w_elig1 & (~w_elig0 | ~r_lastGrant);
      w_grantAny = w_grant0 | w_grant1;
      w_grantId  = w_grant1;
   end

   // Operand steering into the cell; zero when nothing is issued so the cell
   // inputs stay quiet on idle cycles.
   always_comb begin
      mul_src1 = '0;
      mul_src2 = '0;
      if (w_grant0) begin
         mul_src1 = r0_src1;
         mul_src2 = r0_src2;
      end else if (w_grant1) begin
         mul_src1 = r1_src1;
         mul_src2 = r1_src2;
      end
   end

   // Response handshakes and result-capture strobes from the tag pipeline tail.
   always_comb begin
      w_done0    = r_respValid[0] & r0_resp_ready;
      w_done1    = r_respValid[1] & r1_resp_ready;
      w_capture0 = r_tagValid[LastStage] & ~r_tagId[LastStage];
      w_capture1 = r_tagValid[LastStage] &  r_tagId[LastStage];
   end

   // Remember who was granted last so contention alternates between the two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lastGrant <= 1'b1;
      end else if (w_grantAny) begin
         r_lastGrant <= w_grantId;
      end
   end

   // Outstanding flags: set on grant, cleared when the owner takes its result.
   // A grant and a handshake for the same requester cannot coincide because a
   // held response implies the requester is still marked busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= 2'b00;
      end else begin
         r_busy[0] <= (r_busy[0] & ~w_done0) | w_grant0;
         r_busy[1] <= (r_busy[1] & ~w_done1) | w_grant1;
      end
   end

   // Tag pipeline shifting in lockstep with the cell; it never stalls, which
   // is safe because each requester has room for its one outstanding result.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tagValid <= '0;
         r_tagId    <= '0;
      end else begin
         r_tagValid[0] <= w_grantAny;
         r_tagId[0]    <= w_grantId;
         for (int i = 1; i < MUL_LATENCY; i++) begin
            r_tagValid[i] <= r_tagValid[i-1];
            r_tagId[i]    <= r_tagId[i-1];
         end
      end
   end

   // Requester 0 response register: load on capture, hold until accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_respValid[0] <= 1'b0;
         r_result0      <= '0;
      end else if (w_capture0) begin
         r_respValid[0] <= 1'b1;
         r_result0      <= mul_result;
      end else if (w_done0) begin
         r_respValid[0] <= 1'b0;
      end
   end

   // Requester 1 response register: load on capture, hold until accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_respValid[1] <= 1'b0;
         r_result1      <= '0;
      end else if (w_capture1) begin
         r_respValid[1] <= 1'b1;
         r_result1      <= mul_result;
      end else if (w_done1) begin
         r_respValid[1] <= 1'b0;
      end
   end

   // Output mapping.
   always_comb begin
      r0_ready      = w_grant0;
      r1_ready      = w_grant1;
      r0_resp_valid = r_respValid[0];
      r1_resp_valid = r_respValid[1];
      r0_result     = r_result0;
      r1_result     = r_result1;
      busy          = |r_busy;
   end

endmodule

// File: tb/tb_cpu_mult_arbiter.sv
// tb_cpu_mult_arbiter
// Directed bench for the shared-multiplier arbiter with a behavioural model of
// the pipelined multiplier cell attached to the cell-side ports.

module tb_cpu_mult_arbiter;

   localparam int MulLatency = 1;

   logic        clk;
   logic        reset;
   logic        r0_valid, r0_ready, r0_resp_valid, r0_resp_ready;
   logic [31:0] r0_src1, r0_src2, r0_result;
   logic        r1_valid, r1_ready, r1_resp_valid, r1_resp_ready;
   logic [31:0] r1_src1, r1_src2, r1_result;
   logic [31:0] mul_src1, mul_src2, mul_result;
   logic        busy;

   int checks;
   int failures;

   typedef struct {
      logic        rst;
      logic        v0;
      logic [31:0] a0;
      logic [31:0] b0;
      logic        rr0;
      logic        v1;
      logic [31:0] a1;
      logic [31:0] b1;
      logic        rr1;
      logic        eRdy0;
      logic        eRdy1;
      logic [31:0] eMs1;
      logic [31:0] eMs2;
      logic        eRv0;
      logic [31:0] eRes0;
      logic        eRv1;
      logic [31:0] eRes1;
      logic        eBusy;
   } VectorRow_t;

   VectorRow_t rows[$];

   cpu_mult_arbiter #(
      .MUL_LATENCY(MulLatency),
      .DATA_W(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .r0_valid(r0_valid),
      .r0_ready(r0_ready),
      .r0_src1(r0_src1),
      .r0_src2(r0_src2),
      .r0_resp_valid(r0_resp_valid),
      .r0_resp_ready(r0_resp_ready),
      .r0_result(r0_result),
      .r1_valid(r1_valid),
      .r1_ready(r1_ready),
      .r1_src1(r1_src1),
      .r1_src2(r1_src2),
      .r1_resp_valid(r1_resp_valid),
      .r1_resp_ready(r1_resp_ready),
      .r1_result(r1_result),
      .mul_src1(mul_src1),
      .mul_src2(mul_src2),
      .mul_result(mul_result),
      .busy(busy)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Multiplier cell model: MulLatency register stages of the low product.
   logic [31:0] cellPipe [MulLatency];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MulLatency; i++) cellPipe[i] <= '0;
      end else begin
         cellPipe[0] <= mul_src1 * mul_src2;
         for (int i = 1; i < MulLatency; i++) cellPipe[i] <= cellPipe[i-1];
      end
   end
   assign mul_result = cellPipe[MulLatency-1];

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before the test sequence finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s got=%h want=%h", name, actual, expected);
      end
   endtask

   task automatic checkBit(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s got=%b want=%b", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic addRow(input logic rst,
                         input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic rr0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic rr1,
                         input logic eRdy0, input logic eRdy1,
                         input logic [31:0] eMs1, input logic [31:0] eMs2,
                         input logic eRv0, input logic [31:0] eRes0,
                         input logic eRv1, input logic [31:0] eRes1,
                         input logic eBusy);
      VectorRow_t r;
      r.rst = rst;   r.v0 = v0;  r.a0 = a0;  r.b0 = b0;  r.rr0 = rr0;
      r.v1 = v1;     r.a1 = a1;  r.b1 = b1;  r.rr1 = rr1;
      r.eRdy0 = eRdy0; r.eRdy1 = eRdy1; r.eMs1 = eMs1; r.eMs2 = eMs2;
      r.eRv0 = eRv0; r.eRes0 = eRes0; r.eRv1 = eRv1; r.eRes1 = eRes1;
      r.eBusy = eBusy;
      rows.push_back(r);
   endtask

   task automatic applyStimulus(input VectorRow_t r);
      reset         = r.rst;
      r0_valid      = r.v0;
      r0_src1       = r.a0;
      r0_src2       = r.b0;
      r0_resp_ready = r.rr0;
      r1_valid      = r.v1;
      r1_src1       = r.a1;
      r1_src2       = r.b1;
      r1_resp_ready = r.rr1;
   endtask

   task automatic checkRow(input int idx, input VectorRow_t r);
      checkBit($sformatf("row%0d r0_ready", idx), r0_ready, r.eRdy0);
      checkBit($sformatf("row%0d r1_ready", idx), r1_ready, r.eRdy1);
      checkOutput($sformatf("row%0d mul_src1", idx), mul_src1, r.eMs1);
      checkOutput($sformatf("row%0d mul_src2", idx), mul_src2, r.eMs2);
      checkBit($sformatf("row%0d r0_resp_valid", idx), r0_resp_valid, r.eRv0);
      checkOutput($sformatf("row%0d r0_result", idx), r0_result, r.eRes0);
      checkBit($sformatf("row%0d r1_resp_valid", idx), r1_resp_valid, r.eRv1);
      checkOutput($sformatf("row%0d r1_result", idx), r1_result, r.eRes1);
      checkBit($sformatf("row%0d busy", idx), busy, r.eBusy);
   endtask

   task automatic idleInputs();
      r0_valid = 1'b0; r0_src1 = '0; r0_src2 = '0; r0_resp_ready = 1'b1;
      r1_valid = 1'b0; r1_src1 = '0; r1_src2 = '0; r1_resp_ready = 1'b1;
   endtask

   // Main sequence.
   initial begin
      int cnt0;
      int cnt1;
      int prevId;
      int diff;
      logic [31:0] exp0;
      logic [31:0] exp1;

      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      idleInputs();
      repeat (2) @(posedge clk);
      #1;

      // rst, r0{v,a,b,rr}, r1{v,a,b,rr}, rdy0, rdy1, ms1, ms2, rv0, res0, rv1, res1, busy
      addRow(1, 1, 3, 5, 1,                 1, 9, 9, 1,                       0, 0, 0, 0,                           0, 0,            0, 0,  0);
      addRow(0, 1, 7, 6, 1,                 1, 9, 9, 1,                       1, 0, 7, 6,                           0, 0,            0, 0,  0);
      addRow(0, 1, 7, 6, 1,                 1, 9, 9, 1,                       0, 1, 9, 9,                           0, 0,            0, 0,  1);
      addRow(0, 1, 7, 6, 1,                 1, 9, 9, 1,                       0, 0, 0, 0,                           1, 42,           0, 0,  1);
      addRow(0, 1, 32'hFFFF_FFFF, 2, 1,     1, 9, 9, 1,                       1, 0, 32'hFFFF_FFFF, 2,               0, 42,           1, 81, 1);
      addRow(0, 1, 32'hFFFF_FFFF, 2, 1,     1, 32'h0001_0000, 32'h0001_0000, 1, 0, 1, 32'h0001_0000, 32'h0001_0000, 0, 42,           0, 81, 1);
      addRow(0, 0, 0, 0, 1,                 0, 0, 0, 1,                       0, 0, 0, 0,                           1, 32'hFFFF_FFFE, 0, 81, 1);
      addRow(0, 0, 0, 0, 1,                 0, 0, 0, 0,                       0, 0, 0, 0,                           0, 32'hFFFF_FFFE, 1, 0,  1);
      addRow(0, 1, 3, 5, 1,                 1, 2, 3, 0,                       1, 0, 3, 5,                           0, 32'hFFFF_FFFE, 1, 0,  1);
      addRow(0, 0, 0, 0, 1,                 1, 2, 3, 1,                       0, 0, 0, 0,                           0, 32'hFFFF_FFFE, 1, 0,  1);
      addRow(0, 0, 0, 0, 1,                 1, 2, 3, 1,                       0, 1, 2, 3,                           1, 15,           0, 0,  1);
      addRow(0, 0, 0, 0, 1,                 0, 0, 0, 1,                       0, 0, 0, 0,                           0, 15,           0, 0,  1);
      addRow(0, 0, 0, 0, 1,                 0, 0, 0, 1,                       0, 0, 0, 0,                           0, 15,           1, 6,  1);
      addRow(0, 0, 0, 0, 0,                 0, 0, 0, 0,                       0, 0, 0, 0,                           0, 15,           0, 6,  0);

      for (int i = 0; i < rows.size(); i++) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         checkRow(i, rows[i]);
         tick();
      end

      // Backpressure: r0 holds its response for 10 cycles while r1 keeps going.
      for (int k = 0; k < 12; k++) begin
         r0_valid = 1'b1; r0_src1 = 32'd11; r0_src2 = 32'd13; r0_resp_ready = (k >= 10);
         r1_valid = 1'b1; r1_src1 = k + 1;  r1_src2 = 32'd3;  r1_resp_ready = 1'b1;
         @(negedge clk);
         checkBit($sformatf("bp%0d r0_ready", k), r0_ready, (k == 0 || k == 11));
         checkBit($sformatf("bp%0d r1_ready", k), r1_ready, (k >= 1 && (k - 1) % 3 == 0));
         checkBit($sformatf("bp%0d r0_resp_valid", k), r0_resp_valid, (k >= 2 && k <= 10));
         if (k >= 2 && k <= 10) checkOutput($sformatf("bp%0d r0_result", k), r0_result, 32'd143);
         checkBit($sformatf("bp%0d r1_resp_valid", k), r1_resp_valid, (k == 3 || k == 6 || k == 9));
         if (k == 3 || k == 6 || k == 9) checkOutput($sformatf("bp%0d r1_result", k), r1_result, (k - 1) * 3);
         tick();
      end
      idleInputs();
      for (int d = 0; d < 4; d++) begin
         @(negedge clk);
         if (d == 1) begin
            checkBit("bp drain r0_resp_valid", r0_resp_valid, 1'b1);
            checkOutput("bp drain r0_result", r0_result, 32'd143);
         end
         tick();
      end
      @(negedge clk);
      checkBit("bp drained busy", busy, 1'b0);
      tick();

      // Round-robin fairness with immediate response acceptance.
      cnt0 = 0; cnt1 = 0; prevId = -1; exp0 = '0; exp1 = '0;
      for (int c = 0; c < 100; c++) begin
         r0_valid = 1'b1; r0_src1 = c + 1; r0_src2 = 32'd7; r0_resp_ready = 1'b1;
         r1_valid = 1'b1; r1_src1 = c + 2; r1_src2 = 32'd5; r1_resp_ready = 1'b1;
         @(negedge clk);
         checkBit($sformatf("fair%0d both_ready", c), r0_ready & r1_ready, 1'b0);
         if (r0_ready) begin
            cnt0++;
            checkOutput($sformatf("fair%0d r0 mul_src1", c), mul_src1, c + 1);
            checkBit($sformatf("fair%0d r0 repeat_grant", c), prevId == 0, 1'b0);
            prevId = 0;
            exp0 = (c + 1) * 7;
         end
         if (r1_ready) begin
            cnt1++;
            checkOutput($sformatf("fair%0d r1 mul_src1", c), mul_src1, c + 2);
            checkBit($sformatf("fair%0d r1 repeat_grant", c), prevId == 1, 1'b0);
            prevId = 1;
            exp1 = (c + 2) * 5;
         end
         if (r0_resp_valid) checkOutput($sformatf("fair%0d r0_result", c), r0_result, exp0);
         if (r1_resp_valid) checkOutput($sformatf("fair%0d r1_result", c), r1_result, exp1);
         tick();
      end
      diff = cnt0 - cnt1;
      if (diff < 0) diff = -diff;
      checkBit("fair grant_count_diff", diff <= 1, 1'b1);
      checkBit("fair grant_total", (cnt0 + cnt1) >= 60, 1'b1);
      idleInputs();
      repeat (4) tick();

      // Reset arriving the cycle after r1 issues 4x4.
      r1_valid = 1'b1; r1_src1 = 32'd4; r1_src2 = 32'd4;
      @(negedge clk);
      checkBit("rst r1_ready issue", r1_ready, 1'b1);
      tick();
      reset = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
      @(negedge clk);
      checkBit("rst r0_ready in_reset", r0_ready, 1'b0);
      checkBit("rst r1_ready in_reset", r1_ready, 1'b0);
      checkBit("rst r1_resp_valid in_reset", r1_resp_valid, 1'b0);
      tick();
      reset = 1'b0;
      idleInputs();
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         checkBit($sformatf("rst post%0d r1_resp_valid", j), r1_resp_valid, 1'b0);
         checkBit($sformatf("rst post%0d busy", j), busy, 1'b0);
         checkOutput($sformatf("rst post%0d r1_result", j), r1_result, 32'd0);
         tick();
      end
      r0_valid = 1'b1; r1_valid = 1'b1;
      @(negedge clk);
      checkBit("rst contention r0_ready", r0_ready, 1'b1);
      checkBit("rst contention r1_ready", r1_ready, 1'b0);
      tick();
      idleInputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
